// File: rtl/pickup_field.sv
// pickup_field: a field of NUM_ITEMS square pickups for the snake game.
// Each slot is ACTIVE (drawn, edible), COOLDOWN (eaten, counting snake
// steps) or PENDING (waiting for a random on-screen origin from the LFSR).
//
// Ports
//   vga_clk                  sole clock, rising edge
//   reset                    synchronous, active-high; clears everything
//   game_over                synchronous field restart; score is held
//   step_en                  one-cycle pulse per snake move
//   head_x, head_y           snake head origin, sampled on step_en
//   pixel_col, pixel_row     current VGA pixel
//   pickup_px, pickup_px_idx pixel-inside-pickup flag and slot index (2-cycle latency)
//   eat_pulse, eat_idx       one-cycle eat strobe and eaten slot index
//   active                   per-slot ACTIVE flags
//   score                    saturating count of pickups eaten
module pickup_field #(
  parameter int unsigned NUM_ITEMS     = 4,
  parameter int unsigned COORD_W       = 12,
  parameter int unsigned SIZE          = 10,
  parameter int unsigned X_LIMIT       = 630,
  parameter int unsigned Y_LIMIT       = 470,
  parameter int unsigned RESPAWN_STEPS = 8,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic                 game_over,
  input  logic                 step_en,
  input  logic [COORD_W-1:0]   head_x,
  input  logic [COORD_W-1:0]   head_y,
  input  logic [COORD_W-1:0]   pixel_col,
  input  logic [COORD_W-1:0]   pixel_row,
  output logic                 pickup_px,
  output logic [2:0]           pickup_px_idx,
  output logic                 eat_pulse,
  output logic [2:0]           eat_idx,
  output logic [NUM_ITEMS-1:0] active,
  output logic [SCORE_W-1:0]   score
);

  localparam int unsigned EXT_W = COORD_W + 1;
  localparam int unsigned CNT_W = $clog2(RESPAWN_STEPS + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    SLOT_ACTIVE   = 2'd0,
    SLOT_COOLDOWN = 2'd1,
    SLOT_PENDING  = 2'd2
  } slot_state_t;

  slot_state_t                          state_q [NUM_ITEMS];
  slot_state_t                          state_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0][COORD_W-1:0]    x_q, x_d;
  logic [NUM_ITEMS-1:0][COORD_W-1:0]    y_q, y_d;
  logic [NUM_ITEMS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  // PENDING slot whose origin has been loaded; it turns ACTIVE next cycle
  logic [NUM_ITEMS-1:0]                 placed_q, placed_d;
  logic [NUM_ITEMS-1:0]                 active_d;
  logic [NUM_ITEMS-1:0]                 hit_c;
  logic                                 eat_found;
  logic [2:0]                           eat_idx_d;
  logic                                 serviced;
  logic [SCORE_W-1:0]                   score_d;
  logic                                 step_live;

  logic [15:0]                          lfsr_q;
  logic                                 lfsr_fb;
  logic [11:0]                          cand_y_raw;
  logic [COORD_W-1:0]                   cand_x;
  logic [COORD_W-1:0]                   cand_y;
  logic                                 cand_ok;

  logic [NUM_ITEMS-1:0]                 inside_c;
  logic [NUM_ITEMS-1:0]                 inside_q;
  logic [2:0]                           px_idx_c;

  // game_over on the same cycle as a step cancels the eat
  assign step_live = step_en && !game_over;

  // Random origin candidates: x^16+x^14+x^13+x^11+1 Fibonacci LFSR
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand_y_raw = {lfsr_q[7:0], lfsr_q[15:12]};
  assign cand_x     = COORD_W'(lfsr_q);
  assign cand_y     = COORD_W'(cand_y_raw);
  assign cand_ok    = ({1'b0, cand_x} < EXT_W'(X_LIMIT)) &&
                      ({1'b0, cand_y} < EXT_W'(Y_LIMIT));

  always_ff @(posedge vga_clk) begin
    if (reset || game_over) lfsr_q <= LFSR_SEED;
    else                    lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  // Head-vs-slot hit test, widened one bit so origin+SIZE never wraps
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      hit_c[i] = ({1'b0, head_x} >= {1'b0, x_q[i]}) &&
                 ({1'b0, head_x} <  ({1'b0, x_q[i]} + EXT_W'(SIZE))) &&
                 ({1'b0, head_y} >= {1'b0, y_q[i]}) &&
                 ({1'b0, head_y} <  ({1'b0, y_q[i]} + EXT_W'(SIZE)));
    end
  end

  // Slot next-state: eat, cooldown countdown, respawn servicing
  always_comb begin
    for (int i = 0; i < int'(NUM_ITEMS); i++) state_d[i] = state_q[i];
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    placed_d  = placed_q;
    active_d  = '0;
    eat_found = 1'b0;
    eat_idx_d = 3'd0;
    serviced  = 1'b0;
    score_d   = score;

    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      case (state_q[i])
        SLOT_ACTIVE: begin
          if (step_live && hit_c[i] && !eat_found) begin
            eat_found  = 1'b1;
            eat_idx_d  = 3'(i);
            state_d[i] = SLOT_COOLDOWN;
            cnt_d[i]   = CNT_W'(RESPAWN_STEPS);
          end
        end
        SLOT_COOLDOWN: begin
          if (step_live) begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i]  = SLOT_PENDING;
              cnt_d[i]    = '0;
              placed_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
        end
        SLOT_PENDING: begin
          if (placed_q[i]) begin
            state_d[i]  = SLOT_ACTIVE;
            placed_d[i] = 1'b0;
          end else if (!serviced) begin
            // one candidate per cycle; a rejected one is simply retried
            serviced = 1'b1;
            if (cand_ok) begin
              x_d[i]      = cand_x;
              y_d[i]      = cand_y;
              placed_d[i] = 1'b1;
            end
          end
        end
        default: state_d[i] = SLOT_ACTIVE;
      endcase
      active_d[i] = (state_d[i] == SLOT_ACTIVE);
    end

    if (eat_found && (score != {SCORE_W{1'b1}})) score_d = score + SCORE_W'(1);
  end

  // Slot state register and registered game outputs
  always_ff @(posedge vga_clk) begin
    if (reset || game_over) begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        state_q[i] <= SLOT_ACTIVE;
        x_q[i]     <= COORD_W'(200 + 40 * i);
        y_q[i]     <= COORD_W'(200);
        cnt_q[i]   <= '0;
      end
      placed_q  <= '0;
      active    <= '1;
      eat_pulse <= 1'b0;
      eat_idx   <= 3'd0;
      if (reset) score <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) state_q[i] <= state_d[i];
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      placed_q  <= placed_d;
      active    <= active_d;
      eat_pulse <= eat_found;
      eat_idx   <= eat_idx_d;
      score     <= score_d;
    end
  end

  // Render stage 1: per-slot inside flags for the current pixel
  always_comb begin
    inside_c = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      inside_c[i] = (state_q[i] == SLOT_ACTIVE) &&
                    ({1'b0, pixel_col} >= {1'b0, x_q[i]}) &&
                    ({1'b0, pixel_col} <  ({1'b0, x_q[i]} + EXT_W'(SIZE))) &&
                    ({1'b0, pixel_row} >= {1'b0, y_q[i]}) &&
                    ({1'b0, pixel_row} <  ({1'b0, y_q[i]} + EXT_W'(SIZE)));
    end
  end

  // Render stage 2 priority: lowest index wins on overlap
  always_comb begin
    px_idx_c = 3'd0;
    for (int i = int'(NUM_ITEMS) - 1; i >= 0; i--) begin
      if (inside_q[i]) px_idx_c = 3'(i);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset || game_over) begin
      inside_q      <= '0;
      pickup_px     <= 1'b0;
      pickup_px_idx <= 3'd0;
    end else begin
      inside_q      <= inside_c;
      pickup_px     <= |inside_q;
      pickup_px_idx <= px_idx_c;
    end
  end

endmodule

// File: tb/tb_pickup_field.sv
// Self-checking bench for pickup_field: directed steps for the key scenarios
// followed by a randomized phase, all compared every cycle against a
// behavioural model of the pickup field.
module tb_pickup_field;

  localparam int N = 4;
  localparam int SZ = 10;
  localparam int RESP = 8;
  localparam int SMAX = 255;

  logic        vga_clk;
  logic        reset;
  logic        game_over;
  logic        step_en;
  logic [11:0] head_x, head_y, pixel_col, pixel_row;
  logic        pickup_px;
  logic [2:0]  pickup_px_idx;
  logic        eat_pulse;
  logic [2:0]  eat_idx;
  logic [3:0]  active;
  logic [7:0]  score;

  int n_assert = 0;
  int n_fail   = 0;

  pickup_field dut (
    .vga_clk(vga_clk), .reset(reset), .game_over(game_over), .step_en(step_en),
    .head_x(head_x), .head_y(head_y), .pixel_col(pixel_col), .pixel_row(pixel_row),
    .pickup_px(pickup_px), .pickup_px_idx(pickup_px_idx),
    .eat_pulse(eat_pulse), .eat_idx(eat_idx), .active(active), .score(score)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Model state: 0 active, 1 cooldown, 2 pending (no origin), 3 origin chosen
  int          m_st [N];
  int          m_cnt[N];
  int          m_x  [N];
  int          m_y  [N];
  logic [15:0] m_lf;
  int          m_score;
  int          m_ep, m_eidx;
  int          m_px, m_pidx;
  int          p_px, p_pidx;

  function automatic bit in_sq(int v, int lo);
    return (v >= lo) && (v < lo + SZ);
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] a;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = (m_st[i] == 0);
    return a;
  endfunction

  task automatic model_tick();
    int pst[N];
    int cx, cy;
    bit done;
    for (int i = 0; i < N; i++) pst[i] = m_st[i];
    if (reset || game_over) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_x[i] = 200 + 40 * i; m_y[i] = 200;
      end
      m_lf = 16'hACE1;
      if (reset) m_score = 0;
      m_ep = 0; m_eidx = 0; m_px = 0; m_pidx = 0; p_px = 0; p_pidx = 0;
      return;
    end
    // two-cycle render pipeline
    m_px = p_px; m_pidx = p_pidx;
    p_px = 0; p_pidx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pst[i] == 0 && in_sq(int'(pixel_col), m_x[i]) && in_sq(int'(pixel_row), m_y[i])) begin
        p_px = 1; p_pidx = i;
      end
    end
    // at most one eat per step, lowest index
    m_ep = 0; m_eidx = 0;
    if (step_en) begin
      for (int i = 0; i < N; i++) begin
        if (m_ep == 0 && pst[i] == 0 &&
            in_sq(int'(head_x), m_x[i]) && in_sq(int'(head_y), m_y[i])) begin
          m_ep = 1; m_eidx = i; m_st[i] = 1; m_cnt[i] = RESP;
          if (m_score < SMAX) m_score++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (step_en && pst[i] == 1) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_st[i] = 2;
      end
    end
    done = 0;
    for (int i = 0; i < N; i++) begin
      if (pst[i] == 3) m_st[i] = 0;
      else if (pst[i] == 2 && !done) begin
        done = 1;
        cx = int'(m_lf[11:0]);
        cy = int'({m_lf[7:0], m_lf[15:12]});
        if (cx < 630 && cy < 470) begin
          m_x[i] = cx; m_y[i] = cy; m_st[i] = 3;
        end
      end
    end
    m_lf = {m_lf[14:0], m_lf[15] ^ m_lf[13] ^ m_lf[12] ^ m_lf[10]};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances with the inputs the DUT sampled, then compare
  task automatic tick();
    @(posedge vga_clk);
    model_tick();
    #1;
    chk("active",        32'(active),        32'(model_active()));
    chk("score",         32'(score),         32'(m_score));
    chk("eat_pulse",     32'(eat_pulse),     32'(m_ep));
    chk("eat_idx",       32'(eat_idx),       32'(m_eidx));
    chk("pickup_px",     32'(pickup_px),     32'(m_px));
    chk("pickup_px_idx", 32'(pickup_px_idx), 32'(m_pidx));
  endtask

  task automatic do_reset();
    reset = 1'b1; step_en = 1'b0; game_over = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic step_at(input int hx, input int hy);
    head_x = 12'(hx); head_y = 12'(hy); step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  int waited;
  int r, j, v;

  initial begin
    reset = 1'b1; game_over = 1'b0; step_en = 1'b0;
    head_x = '0; head_y = '0; pixel_col = '0; pixel_row = '0;

    // reset state
    do_reset();
    chk("rst_active",   32'(active),        32'hF);
    chk("rst_score",    32'(score),         32'd0);
    chk("rst_eat",      32'(eat_pulse),     32'd0);
    chk("rst_eat_idx",  32'(eat_idx),       32'd0);
    chk("rst_px",       32'(pickup_px),     32'd0);
    chk("rst_px_idx",   32'(pickup_px_idx), 32'd0);

    // basic eat of slot 0
    step_at(205, 205);
    chk("eat0_pulse",  32'(eat_pulse), 32'd1);
    chk("eat0_idx",    32'(eat_idx),   32'd0);
    chk("eat0_score",  32'(score),     32'd1);
    chk("eat0_active", 32'(active),    32'hE);
    tick();
    chk("eat0_pulse_drop", 32'(eat_pulse), 32'd0);

    // exclusive edges, then slot 1
    do_reset();
    step_at(210, 205);
    chk("xedge_no_eat", 32'(eat_pulse), 32'd0);
    step_at(205, 210);
    chk("yedge_no_eat", 32'(eat_pulse), 32'd0);
    step_at(199, 205);
    chk("xlow_no_eat", 32'(eat_pulse), 32'd0);
    step_at(240, 209);
    chk("slot1_eat",   32'(eat_pulse), 32'd1);
    chk("slot1_idx",   32'(eat_idx),   32'd1);
    chk("slot1_active", 32'(active),   32'hD);

    // cooldown and respawn of slot 0
    do_reset();
    step_at(205, 205);
    for (int k = 0; k < RESP - 1; k++) begin
      step_at(0, 0);
      tick();
      chk("cool_inactive", 32'(active[0]), 32'd0);
    end
    step_at(0, 0);
    chk("pend_inactive", 32'(active[0]), 32'd0);
    waited = 0;
    while (active[0] !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    chk("respawn_in_window", 32'(active[0]), 32'd1);
    chk("respawn_x_lt_limit", 32'(dut.x_q[0] < 12'd630), 32'd1);
    chk("respawn_y_lt_limit", 32'(dut.y_q[0] < 12'd470), 32'd1);
    chk("respawn_x_model", 32'(dut.x_q[0]), 32'(m_x[0]));
    chk("respawn_y_model", 32'(dut.y_q[0]), 32'(m_y[0]));

    // render latency
    do_reset();
    pixel_col = 12'd202; pixel_row = 12'd203;
    tick();
    chk("render_lat1_px", 32'(pickup_px), 32'd0);
    tick();
    chk("render_lat2_px",  32'(pickup_px),     32'd1);
    chk("render_lat2_idx", 32'(pickup_px_idx), 32'd0);
    pixel_col = 12'd245; pixel_row = 12'd209;
    tick(); tick();
    chk("render_slot1_px",  32'(pickup_px),     32'd1);
    chk("render_slot1_idx", 32'(pickup_px_idx), 32'd1);
    pixel_col = 12'd250; pixel_row = 12'd250;
    tick(); tick();
    chk("render_out_px",  32'(pickup_px),     32'd0);
    chk("render_out_idx", 32'(pickup_px_idx), 32'd0);

    // score saturation, game_over restores slots but keeps score
    do_reset();
    for (int k = 0; k < SMAX; k++) begin
      step_at(205, 205);
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
    end
    chk("sat_score_full", 32'(score), 32'd255);
    step_at(205, 205);
    chk("sat_score_hold", 32'(score),     32'd255);
    chk("sat_eat_pulse",  32'(eat_pulse), 32'd1);

    // game_over during cooldown with a simultaneous hitting step
    do_reset();
    step_at(205, 205);
    tick();
    step_at(0, 0);
    head_x = 12'd245; head_y = 12'd205; step_en = 1'b1; game_over = 1'b1;
    tick();
    step_en = 1'b0; game_over = 1'b0;
    chk("go_no_eat", 32'(eat_pulse), 32'd0);
    chk("go_active", 32'(active),    32'hF);
    chk("go_score",  32'(score),     32'd1);
    for (int i = 0; i < N; i++) begin
      chk("go_x", 32'(dut.x_q[i]), 32'(200 + 40 * i));
      chk("go_y", 32'(dut.y_q[i]), 32'd200);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step_en   = ($urandom_range(0, 3) == 0);
      game_over = ($urandom_range(0, 199) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      r = int'($urandom_range(0, 3));
      j = int'($urandom_range(0, N - 1));
      if (r == 0) begin
        head_x = 12'($urandom_range(0, 4095));
        head_y = 12'($urandom_range(0, 4095));
      end else begin
        v = m_x[j] - 1 + int'($urandom_range(0, SZ + 1));
        head_x = 12'((v < 0) ? 0 : v);
        v = m_y[j] - 1 + int'($urandom_range(0, SZ + 1));
        head_y = 12'((v < 0) ? 0 : v);
      end
      j = int'($urandom_range(0, N - 1));
      v = m_x[j] - 1 + int'($urandom_range(0, SZ + 1));
      pixel_col = 12'((v < 0) ? 0 : v);
      v = m_y[j] - 1 + int'($urandom_range(0, SZ + 1));
      pixel_row = 12'((v < 0) ? 0 : v);
      tick();
    end
    reset = 1'b0; game_over = 1'b0; step_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
